// File: rtl/mac_operand_splitter_pkg.sv
// Widths, cfg constants and lane payload type for the MAC operand splitter.
package mac_operand_splitter_pkg;
  `include "mac_const.vh"

  localparam int unsigned N = `MAC_MIN_WIDTH;
  localparam int unsigned W = 4 * N;
  localparam int unsigned LW = 8 * N;

  localparam logic [1:0] CFG_DUAL = `MAC_DUAL;
  localparam logic [1:0] CFG_QUAD = `MAC_QUAD;

  typedef struct packed {
    logic [N-1:0] a3;
    logic [N-1:0] a2;
    logic [N-1:0] a1;
    logic [N-1:0] a0;
    logic [N-1:0] b3;
    logic [N-1:0] b2;
    logic [N-1:0] b1;
    logic [N-1:0] b0;
  } lane_ops_t;

  function automatic logic [1:0] last_pass_idx(input logic [1:0] cfg);
    return 2'(mac_pass_count(cfg) - 3'd1);
  endfunction
endpackage

// File: rtl/mac_const.vh
// Shared MAC constants: minimum lane width, cfg encodings and pass count.
// Included by the splitter package and by the combiner.
`ifndef MAC_CONST_VH
`define MAC_CONST_VH
`define MAC_MIN_WIDTH 8
`define MAC_SINGLE 2'b00
`define MAC_DUAL   2'b01
`define MAC_QUAD   2'b10
`endif

// Number of narrow-multiplier passes per operation; unknown cfg runs as single.
function automatic logic [2:0] mac_pass_count(input logic [1:0] cfg);
  case (cfg)
    `MAC_DUAL: return 3'd2;
    `MAC_QUAD: return 3'd4;
    default:   return 3'd1;
  endcase
endfunction

// File: rtl/mac_operand_splitter_lane_mux.sv
// Combinational map of (cfg, pass, A, B) onto the four narrow multiplier lanes.
module mac_lane_mux
  import mac_operand_splitter_pkg::*;
(
  input  logic [1:0]    cfg,
  input  logic [1:0]    pass_idx,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [LW-1:0] lanes_c
);

  logic [1:0] bsel [4];
  lane_ops_t  ops;

  // Lane k always multiplies A_k; only the B slice choice depends on mode.
  always_comb begin
    for (int k = 0; k < 4; k++) bsel[k] = 2'(k);
    case (cfg)
      CFG_DUAL: begin
        bsel[0] = {1'b0, pass_idx[0]};
        bsel[1] = {1'b0, pass_idx[0]};
        bsel[2] = {1'b1, pass_idx[0]};
        bsel[3] = {1'b1, pass_idx[0]};
      end
      CFG_QUAD: begin
        for (int k = 0; k < 4; k++) bsel[k] = pass_idx;
      end
      default: ;
    endcase
  end

  always_comb begin
    ops    = '0;
    ops.a0 = a[0*N +: N];
    ops.a1 = a[1*N +: N];
    ops.a2 = a[2*N +: N];
    ops.a3 = a[3*N +: N];
    ops.b0 = b[N*int'(bsel[0]) +: N];
    ops.b1 = b[N*int'(bsel[1]) +: N];
    ops.b2 = b[N*int'(bsel[2]) +: N];
    ops.b3 = b[N*int'(bsel[3]) +: N];
    lanes_c = ops;
  end

endmodule

// File: rtl/mac_operand_splitter.sv
// Splits a wide operand pair into 1/2/4 passes of narrow lane operands.
// Lanes are computed from next-state values so every output comes from a flop.
module mac_operand_splitter
  import mac_operand_splitter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_cfg,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   lane_a0,
  output logic [N-1:0]   lane_a1,
  output logic [N-1:0]   lane_a2,
  output logic [N-1:0]   lane_a3,
  output logic [N-1:0]   lane_b0,
  output logic [N-1:0]   lane_b1,
  output logic [N-1:0]   lane_b2,
  output logic [N-1:0]   lane_b3,
  output logic [1:0]     pass_idx,
  output logic           pass_last,
  output logic [1:0]     pass_cfg
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    cfg_q, cfg_d, idx_q, idx_d;
  logic          valid_q, valid_d, last_q, last_d;
  lane_ops_t     lanes_q;
  logic [LW-1:0] lanes_d;
  logic          in_hs, out_hs;

  // Ready again on the final pass so the next operation issues bubble-free.
  always_comb begin
    in_ready = en & ((state_q == IDLE) | (last_q & out_ready));
    in_hs    = in_valid & in_ready;
    out_hs   = valid_q & out_ready & en;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (in_hs) begin
      state_d = ISSUE;
      a_d     = in_a;
      b_d     = in_b;
      cfg_d   = in_cfg;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (out_hs) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
    last_d = valid_d & (idx_d == last_pass_idx(cfg_d));
  end

  mac_lane_mux u_lane_mux (
    .cfg      (cfg_d),
    .pass_idx (idx_d),
    .a        (a_d),
    .b        (b_d),
    .lanes_c  (lanes_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cfg_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lanes_q <= lanes_d;
    end
  end

  assign out_valid = valid_q;
  assign pass_idx  = idx_q;
  assign pass_last = last_q;
  assign pass_cfg  = cfg_q;
  assign lane_a0   = lanes_q.a0;
  assign lane_a1   = lanes_q.a1;
  assign lane_a2   = lanes_q.a2;
  assign lane_a3   = lanes_q.a3;
  assign lane_b0   = lanes_q.b0;
  assign lane_b1   = lanes_q.b1;
  assign lane_b2   = lanes_q.b2;
  assign lane_b3   = lanes_q.b3;

endmodule
